lcd_dma_scheduler: RTL

//  Frame-level DMA sequencer in front of the AXI3 HP burst reader of the LCD controller.

---
 rtl/lcd_dma_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/lcd_dma_scheduler.sv
// Frame-level burst sequencer for the LCD HP reader: walks a framebuffer in fixed
// bursts, issuing one only when the pixel FIFO can absorb it, and restarts on FRAME_START.
module lcd_dma_scheduler #(
    parameter int BURST_SIZE = 8,
    parameter int FIFO_DEPTH = 1024,
    parameter int LEN_BITS   = 20
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          ENABLE,
    input  logic [29:0]                   BUFFER_START_ADDR,
    input  logic [LEN_BITS-1:0]           FRAME_WORDS,
    input  logic                          FRAME_START,
    input  logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    input  logic                          DMA_READY,
    input  logic                          DMA_RD_DATA_VALID,
    output logic                          DMA_START,
    output logic [29:0]                   DMA_RD_ADDR,
    output logic                          FRAME_DONE,
    output logic                          BUSY
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int RX_W  = $clog2(BURST_SIZE + 1);

    localparam logic [LVL_W-1:0]    SPACE_LIMIT = LVL_W'(FIFO_DEPTH - BURST_SIZE);
    localparam logic [LEN_BITS-1:0] BURST_LEN   = LEN_BITS'(BURST_SIZE);
    localparam logic [29:0]         BURST_STEP  = 30'(BURST_SIZE);
    localparam logic [RX_W-1:0]     RX_LAST     = RX_W'(BURST_SIZE);
    localparam logic [RX_W-1:0]     RX_ONE      = RX_W'(1);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_SPACE = 3'd1;
    localparam logic [2:0] ST_ISSUE      = 3'd2;
    localparam logic [2:0] ST_WAIT_DATA  = 3'd3;
    localparam logic [2:0] ST_SETTLE     = 3'd4;

    logic [2:0]          state_reg,     state_next;
    logic [29:0]         addr_reg,      addr_next;
    logic [LEN_BITS-1:0] remaining_reg, remaining_next;
    logic [RX_W-1:0]     rx_reg,        rx_next;
    logic                pending_reg,   pending_next;
    logic [29:0]         rd_addr_reg,   rd_addr_next;
    logic                done_reg,      done_next;
    logic                busy_reg,      busy_next;

    logic [RX_W-1:0]     rx_inc;
    logic                space_ok;

    assign rx_inc   = rx_reg + RX_ONE;
    assign space_ok = ENABLE && DMA_READY && (FIFO_LEVEL <= SPACE_LIMIT);

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        rx_next        = rx_reg;
        pending_next   = pending_reg;
        rd_addr_next   = rd_addr_reg;
        done_next      = 1'b0;
        busy_next      = busy_reg;

        case (state_reg)
            ST_IDLE: begin
                if (FRAME_START) begin
                    addr_next      = BUFFER_START_ADDR;
                    remaining_next = FRAME_WORDS;
                    pending_next   = 1'b0;
                    if (FRAME_WORDS == '0) begin
                        done_next = 1'b1;
                        busy_next = 1'b0;
                    end else begin
                        state_next = ST_WAIT_SPACE;
                        busy_next  = 1'b1;
                    end
                end
            end
            ST_WAIT_SPACE: begin
                // A restart here wins over a burst that would otherwise start now.
                if (FRAME_START) begin
                    addr_next      = BUFFER_START_ADDR;
                    remaining_next = FRAME_WORDS;
                    pending_next   = 1'b0;
                    if (FRAME_WORDS == '0) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                    end
                end else if (space_ok) begin
                    state_next   = ST_ISSUE;
                    rd_addr_next = addr_reg;
                end
            end
            ST_ISSUE: begin
                rx_next    = '0;
                state_next = ST_WAIT_DATA;
                if (FRAME_START) pending_next = 1'b1;
            end
            ST_WAIT_DATA: begin
                if (FRAME_START) pending_next = 1'b1;
                if (DMA_RD_DATA_VALID) begin
                    rx_next = rx_inc;
                    if (rx_inc == RX_LAST) begin
                        state_next     = ST_SETTLE;
                        addr_next      = addr_reg + BURST_STEP;
                        remaining_next = (remaining_reg >= BURST_LEN) ?
                                         (remaining_reg - BURST_LEN) : '0;
                    end
                end
            end
            ST_SETTLE: begin
                // FIFO_LEVEL now reflects the last word of the burst.
                if (pending_reg || FRAME_START) begin
                    addr_next      = BUFFER_START_ADDR;
                    remaining_next = FRAME_WORDS;
                    pending_next   = 1'b0;
                    if (FRAME_WORDS == '0) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                    end else begin
                        state_next = ST_WAIT_SPACE;
                    end
                end else if (remaining_reg == '0) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                end else begin
                    state_next = ST_WAIT_SPACE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            rx_reg        <= '0;
            pending_reg   <= 1'b0;
            rd_addr_reg   <= '0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            rx_reg        <= rx_next;
            pending_reg   <= pending_next;
            rd_addr_reg   <= rd_addr_next;
            done_reg      <= done_next;
            busy_reg      <= busy_next;
        end
    end

    assign DMA_START   = (state_reg == ST_ISSUE);
    assign DMA_RD_ADDR = rd_addr_reg;
    assign FRAME_DONE  = done_reg;
    assign BUSY        = busy_reg;

endmodule
